pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
- Measures an incoming servo-style PWM signal on a 50 MHz clock: high time and period, both in clock cycles.
- duty uses the same scale as the team's 20 ms servo PWM generator (50_000 = 1 ms), so a captured value can drive that generator directly.
- Used for RC-receiver input, closed-loop checks of the arm's own PWM outputs, and signal-loss detection.

Parameters:
- TIMEOUT, 2_000_000: cycles with no rising edge before the signal is declared lost (40 ms).
- MIN_PERIOD, 250_000: periods shorter than this (5 ms) are discarded as glitches.

Ports:
- clk  in  1  50 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- pwm_in  in  1  asynchronous PWM input
- duty  out  20  last valid high time in cycles; saturates at 1_048_575
- period  out  22  last valid period (rise to rise) in cycles
- valid  out  1  one-cycle strobe: duty/period just updated
- lost  out  1  high while no valid measurement is current

Behaviour:
- Reset (rst_n=0, async) sets:
  - outputs: duty=0, period=0, valid=0, lost=1
  - state=IDLE, counters=0, synchronizer flops=0
- Input path:
  - pwm_in passes through a 2-flop synchronizer s1→s2, then an edge register s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - Both edges see the same delay, so measured widths are exact.
- Counters are 22 bits:
  - per_cnt: reset to 1 on rise, otherwise +1 each cycle.
  - hi_cnt: reset to 1 on rise, +1 while s2=1 in state HIGH, frozen otherwise.
  - Neither counter passes TIMEOUT, because timeout fires first.
- State machine:
  - IDLE: wait for rise → HIGH. No publish, because the first period is incomplete.
  - HIGH: on fall → LOW.
  - LOW: on rise → publish check, then → HIGH.
  - HIGH or LOW: per_cnt == TIMEOUT-1 with no rise → IDLE, lost<=1. duty/period keep their last values.
- Publish check (rise seen in LOW):
  - If per_cnt >= MIN_PERIOD: register period<=per_cnt and duty<=min(hi_cnt, 1_048_575), assert valid=1 for exactly one cycle, set lost<=0.
  - If per_cnt < MIN_PERIOD: no update and no valid, but counters still restart on this rise.
- Latency: duty, period and valid change on the 3rd clk rising edge after the pin's rising edge.
- Boundary cases:
  - Rise and timeout in the same cycle: the rise wins, publish as normal.
  - Constant high or constant low input: timeout after TIMEOUT cycles; lost=1, valid never pulses.
  - After loss: the first rise enters HIGH with no valid. The next qualifying rise publishes and clears lost.
  - duty == period cannot occur, because a fall is required to reach LOW.
  - Reset mid-pulse aborts the measurement. Capture restarts in IDLE, and the first published value needs two rises after reset.
- All logic is in the clk domain; pwm_in is the only asynchronous input.

Test Plan:
- Reset, then 1.5 ms high / 20 ms period, three periods:
  - No valid on the first rise.
  - valid on the 2nd and 3rd rises with duty=75_000, period=1_000_000, lost 1→0 at the first valid.
- Loopback from the team's servo PWM generator with duty=50_000 → captured duty=50_000, period=1_000_000; valid once per 20 ms.
- After lock, hold pwm_in low → lost=1 exactly TIMEOUT cycles after the last synchronized rise; duty/period stay 50_000/1_000_000; no valid.
- Same test with pwm_in held high → lost=1 after TIMEOUT cycles; resume 1 ms/20 ms → lost cleared at the second rise.
- Pulse train with 2 ms period (100_000 cycles) → no valid, outputs unchanged. Then a 20 ms period → valid with correct values.
- Assert rst_n for 3 cycles at mid-high → outputs and lost return to reset values immediately (async). The next valid follows the second subsequent rise.
- Pulse high for 1_100_000 cycles within a 1_200_000-cycle period → duty=1_048_575 (saturated), period=1_200_000.

Source files
------------

// File: rtl/pwm_capture.sv
// Servo-style PWM capture: measures high time and rise-to-rise period in clk cycles,
// publishes them with a one-cycle valid strobe and flags loss of signal.
module pwm_capture #(
    parameter int unsigned TIMEOUT    = 2_000_000,
    parameter int unsigned MIN_PERIOD = 250_000,
    parameter int unsigned DUTY_W     = 20,
    parameter int unsigned PERIOD_W   = 22
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pwm_in,
    output logic [DUTY_W-1:0]   duty,
    output logic [PERIOD_W-1:0] period,
    output logic                valid,
    output logic                lost
);

    localparam logic [PERIOD_W-1:0] TIMEOUT_M1 = PERIOD_W'(TIMEOUT - 1);
    localparam logic [PERIOD_W-1:0] MIN_P      = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] DUTY_MAX   = PERIOD_W'((64'd1 << DUTY_W) - 64'd1);
    localparam logic [PERIOD_W-1:0] CNT_ONE    = PERIOD_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          sync_q, sync_d;
    logic [PERIOD_W-1:0] per_cnt_q, per_cnt_d;
    logic [PERIOD_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [DUTY_W-1:0]   duty_q, duty_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                valid_q, valid_d;
    logic                lost_q, lost_d;

    logic                lvl_c;
    logic                rise_c;
    logic                fall_c;
    logic                timeout_c;

    // Two-flop synchronizer followed by an edge register: sync_q = {s3, s2, s1}.
    assign sync_d    = {sync_q[1:0], pwm_in};
    assign lvl_c     = sync_q[1];
    assign rise_c    = sync_q[1] & ~sync_q[2];
    assign fall_c    = ~sync_q[1] & sync_q[2];
    assign timeout_c = (per_cnt_q == TIMEOUT_M1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sync_q    <= 3'b000;
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
            duty_q    <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            lost_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            per_cnt_q <= per_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
            duty_q    <= duty_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            lost_q    <= lost_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        per_cnt_d = per_cnt_q;
        hi_cnt_d  = hi_cnt_q;
        duty_d    = duty_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        lost_d    = lost_q;

        // Period counter idles in IDLE so it cannot wrap while waiting for a signal.
        if (rise_c) begin
            per_cnt_d = CNT_ONE;
        end else if (state_q != IDLE) begin
            per_cnt_d = per_cnt_q + CNT_ONE;
        end

        if (rise_c) begin
            hi_cnt_d = CNT_ONE;
        end else if ((state_q == HIGH) && lvl_c) begin
            hi_cnt_d = hi_cnt_q + CNT_ONE;
        end

        case (state_q)
            IDLE: begin
                if (rise_c) begin
                    state_d = HIGH;
                end
            end
            HIGH: begin
                // Timeout outranks a coincident fall so the counter can never slip past it.
                if (timeout_c) begin
                    state_d = IDLE;
                    lost_d  = 1'b1;
                end else if (fall_c) begin
                    state_d = LOW;
                end
            end
            LOW: begin
                if (rise_c) begin
                    state_d = HIGH;
                    if (per_cnt_q >= MIN_P) begin
                        period_d = per_cnt_q;
                        duty_d   = (hi_cnt_q > DUTY_MAX) ? DUTY_W'(DUTY_MAX) : DUTY_W'(hi_cnt_q);
                        valid_d  = 1'b1;
                        lost_d   = 1'b0;
                    end
                end else if (timeout_c) begin
                    state_d = IDLE;
                    lost_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign duty   = duty_q;
    assign period = period_q;
    assign valid  = valid_q;
    assign lost   = lost_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: waveforms are built from (high, low) segments and a
// segment-level model predicts every publish; a monitor compares each valid strobe.
module tb_pwm_capture;

    localparam int unsigned T    = 2000;
    localparam int unsigned MINP = 250;
    localparam int unsigned DW   = 8;
    localparam int unsigned PW   = 12;
    localparam int unsigned DMAX = 255;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pwm_in = 1'b0;
    logic [DW-1:0] duty;
    logic [PW-1:0] period;
    logic          valid;
    logic          lost;

    pwm_capture #(
        .TIMEOUT   (T),
        .MIN_PERIOD(MINP),
        .DUTY_W    (DW),
        .PERIOD_W  (PW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pwm_in(pwm_in),
        .duty  (duty),
        .period(period),
        .valid (valid),
        .lost  (lost)
    );

    always #10 clk = ~clk;

    typedef struct {
        int unsigned duty;
        int unsigned period;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    bit          have_prev = 1'b0;
    int unsigned prev_h = 0;
    int unsigned prev_len = 0;
    bit          m_lost = 1'b1;
    int unsigned last_duty = 0;
    int unsigned last_period = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // A rise closes the previous segment: publish it if it was a full, non-glitch,
    // non-timed-out period.
    task automatic model_rise(input int unsigned h, input int unsigned len);
        exp_t e;
        if (have_prev && prev_len < T && prev_len >= MINP) begin
            e.duty   = (prev_h > DMAX) ? DMAX : prev_h;
            e.period = prev_len;
            exp_q.push_back(e);
            last_duty   = e.duty;
            last_period = e.period;
            m_lost      = 1'b0;
        end
        have_prev = 1'b1;
        prev_h    = h;
        prev_len  = len;
    endtask

    // Called #1 after a posedge; returns #1 after the posedge where the next rise may start.
    task automatic seg(input int unsigned h, input int unsigned l);
        model_rise(h, h + l);
        pwm_in = 1'b1;
        repeat (h) @(posedge clk);
        #1 pwm_in = 1'b0;
        repeat (l) @(posedge clk);
        #1;
        if (h + l >= T) m_lost = 1'b1;
        if (h + l < T || h + l >= T + 4) check("lost_seg_end", 32'(lost), 32'(m_lost));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL valid_unexpected: got valid=1 duty=%0d period=%0d expected no valid (t=%0t)",
                         duty, period, $time);
            end else begin
                e = exp_q.pop_front();
                check("duty", 32'(duty), e.duty);
                check("period", 32'(period), e.period);
                check("lost_on_valid", 32'(lost), 0);
            end
        end
    end

    initial begin
        #(20 * 150_000);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        #5 rst_n = 1'b0;
        #2;
        check("rst_duty", 32'(duty), 0);
        check("rst_period", 32'(period), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_lost", 32'(lost), 1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // 1.5 ms high / 20 ms period, scaled: first rise only arms the capture.
        repeat (3) seg(75, 925);
        repeat (2) seg(50, 950);

        // Hold low after a lock: lost must rise exactly T cycles after the synchronized rise.
        model_rise(50, T + 500);
        pwm_in = 1'b1;
        repeat (50) @(posedge clk);
        #1 pwm_in = 1'b0;
        repeat (T + 1 - 50) @(posedge clk);
        #1 check("lost_before_timeout", 32'(lost), 0);
        @(posedge clk);
        #1 check("lost_at_timeout", 32'(lost), 1);
        repeat (T + 500 - (T + 2)) @(posedge clk);
        #1;
        m_lost = 1'b1;
        check("hold_low_duty", 32'(duty), last_duty);
        check("hold_low_period", 32'(period), last_period);

        // Held high past the timeout, then resume.
        seg(2500, 100);
        repeat (2) seg(50, 950);

        // Glitch train below the minimum period, then a normal period again.
        repeat (3) seg(30, 70);
        repeat (2) seg(60, 940);

        // Minimum-period and timeout boundaries.
        seg(10, MINP - 1 - 10);
        seg(10, MINP - 10);
        seg(100, T - 1 - 100);
        seg(100, T - 100);
        seg(100, 900);

        // Saturating high time.
        repeat (2) seg(1100, 100);

        for (int i = 0; i < 20; i++) begin
            int unsigned cat;
            int unsigned len;
            int unsigned h;
            cat = $urandom_range(0, 9);
            if (cat == 0) len = $urandom_range(20, MINP - 1);
            else if (cat == 1) len = $urandom_range(T + 4, T + 400);
            else len = $urandom_range(MINP, T - 1);
            h = $urandom_range(1, len - 1);
            seg(h, len - h);
        end

        // Reset mid-high: async clear, then the still-high pin reads as a fresh edge.
        repeat (2) seg(75, 925);
        model_rise(0, 0);
        pwm_in = 1'b1;
        repeat (10) @(posedge clk);
        #4 rst_n = 1'b0;
        #1;
        check("mid_rst_duty", 32'(duty), 0);
        check("mid_rst_period", 32'(period), 0);
        check("mid_rst_valid", 32'(valid), 0);
        check("mid_rst_lost", 32'(lost), 1);
        check("mid_rst_queue_drained", 32'(exp_q.size()), 0);
        have_prev   = 1'b0;
        m_lost      = 1'b1;
        last_duty   = 0;
        last_period = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        seg(200, 800);
        repeat (2) seg(75, 925);

        // Final rise publishes the last full period, then the line goes quiet.
        seg(40, T + 100);
        repeat (10) @(posedge clk);
        #1;
        check("final_queue_drained", 32'(exp_q.size()), 0);
        check("final_duty", 32'(duty), last_duty);
        check("final_period", 32'(period), last_period);
        check("final_lost", 32'(lost), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
